// File: rtl/uart_rx_os16_if.sv
// Serial-line and result bundle for the 16x-oversampling UART receiver.
// master: drives tick and line, consumes the received word and its flags.
// slave:  the receiver itself.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output s_tick, rx,
    input  dout, rx_done, frame_err, parity_err
  );

  modport slave (
    input  s_tick, rx,
    output dout, rx_done, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: 1 start bit, DATA_BITS data bits LSB first,
// optional even parity bit, SB_TICK ticks of stop interval.
// Optional feature: define UART_RX_PARITY_EN to compile in the parity bit and
// the parity_err flag; without it parity_err is tied to 0.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | counting to mid start bit, rejects glitches
// DATA   | sampling data bits every 16 ticks
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting out the stop interval, then reporting the word
module uart_rx_os16 #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_os16_if.slave  bus
);

  // s_cnt must reach SB_TICK-1, so it widens beyond 4 bits for 2 stop bits.
  localparam int CNT_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     s_cnt, s_cnt_nx;
  logic [N_W-1:0]       n, n_nx;
  logic [DATA_BITS-1:0] b, b_nx;
  logic [DATA_BITS-1:0] dout_r, dout_nx;
  logic                 done_r, done_nx;
  logic                 ferr_r, ferr_nx;
  logic                 perr_r, perr_nx;
  logic                 rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nx;
`endif

  // Two-stage synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n      <= '0;
      b      <= '0;
      dout_r <= '0;
      done_r <= 1'b0;
      ferr_r <= 1'b0;
      perr_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      s_cnt  <= s_cnt_nx;
      n      <= n_nx;
      b      <= b_nx;
      dout_r <= dout_nx;
      done_r <= done_nx;
      ferr_r <= ferr_nx;
      perr_r <= perr_nx;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nx;
`endif
    end
  end

  // Next-state and deframing logic; everything except IDLE advances on ticks only.
  always_comb begin
    state_nx = state;
    s_cnt_nx = s_cnt;
    n_nx     = n;
    b_nx     = b;
    dout_nx  = dout_r;
    done_nx  = 1'b0;
    ferr_nx  = 1'b0;
    perr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx   = par_bit;
`endif
    case (state)
      IDLE: begin
        // Edge detect wins over a coincident tick, which is not counted.
        if (!rx_s) begin
          state_nx = START;
          s_cnt_nx = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt == CNT_W'(7)) begin
            if (!rx_s) begin
              state_nx = DATA;
              s_cnt_nx = '0;
              n_nx     = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_cnt_nx = s_cnt + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt == CNT_W'(15)) begin
            b_nx     = {rx_s, b[DATA_BITS-1:1]};
            s_cnt_nx = '0;
            if (n == N_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end else begin
              n_nx = n + N_W'(1);
            end
          end else begin
            s_cnt_nx = s_cnt + CNT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_cnt == CNT_W'(15)) begin
            par_nx   = rx_s;
            s_cnt_nx = '0;
            state_nx = STOP;
          end else begin
            s_cnt_nx = s_cnt + CNT_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt == CNT_W'(SB_TICK - 1)) begin
            // The word is reported even when flagged; the consumer filters it.
            dout_nx  = b;
            done_nx  = 1'b1;
            ferr_nx  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_nx  = ^{b, par_bit};
`endif
            state_nx = IDLE;
          end else begin
            s_cnt_nx = s_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.dout       = dout_r;
  assign bus.rx_done    = done_r;
  assign bus.frame_err  = ferr_r;
  assign bus.parity_err = perr_r;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of frames plus glitch and reset cases.
module tb_uart_rx_os16;
  localparam int DB       = 8;
  localparam int SB       = 16;
  localparam int TICK_DIV = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 8 + 16*DB + 16 + SB;
`else
  localparam int LAT = 8 + 16*DB + SB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_rx_os16_if #(.DATA_BITS(DB)) bus();

  uart_rx_os16 #(.DATA_BITS(DB), .SB_TICK(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Free-running oversample tick, one clk wide every TICK_DIV clks.
  int div_cnt = 0;
  always @(negedge clk) begin
    bus.s_tick <= (div_cnt == TICK_DIV - 1);
    div_cnt    <= (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
  end

  int tick_cnt = 0;
  always @(posedge clk) if (bus.s_tick === 1'b1) tick_cnt <= tick_cnt + 1;

  typedef struct {
    logic [DB-1:0] d;
    logic          fe;
    logic          pe;
    int            t;
  } ev_t;
  ev_t  evq[$];
  int   stray = 0;
  logic prev_done = 1'b0;

  // Capture every reported word and count malformed flag pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rx_done === 1'b1)
        evq.push_back('{bus.dout, bus.frame_err, bus.parity_err, tick_cnt});
      if ((bus.rx_done === 1'b1 && prev_done === 1'b1) ||
          ((bus.frame_err === 1'b1 || bus.parity_err === 1'b1) && bus.rx_done !== 1'b1))
        stray <= stray + 1;
    end
    prev_done <= bus.rx_done;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int start_tick = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (bus.s_tick !== 1'b1);
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) wait_tick();
  endtask

  // Caller sits on a tick edge. align places the detection exactly on a tick.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic par, input bit align);
    if (align) begin
      repeat (5) @(posedge clk);
      #1 bus.rx = 1'b0;
      wait_tick();
      #1 start_tick = tick_cnt;
    end else begin
      #1 bus.rx = 1'b0;
      start_tick = tick_cnt;
    end
    wait_ticks(16);
    for (int i = 0; i < DB; i++) begin
      #1 bus.rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    #1 bus.rx = par;
    wait_ticks(16);
`else
    if (par !== 1'b0 && par !== 1'b1) $display("note: parity field unset");
`endif
    if (stop) begin
      #1 bus.rx = 1'b1;
      wait_ticks(SB);
    end else begin
      #1 bus.rx = 1'b0;
      wait_ticks(12);
      #1 bus.rx = 1'b1;
      wait_ticks(SB - 12);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] data, input logic stop,
                           input logic par, input bit align, input logic [7:0] exp_d,
                           input logic exp_fe, input logic exp_pe);
    ev_t ev;
    send_frame(data, stop, par, align);
    check({name, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      ev = evq.pop_front();
      check({name, "_dout"}, ev.d, exp_d);
      check({name, "_frame_err"}, ev.fe, exp_fe);
      check({name, "_parity_err"}, ev.pe, exp_pe);
      check({name, "_latency"}, ev.t - start_tick, LAT);
    end
    evq.delete();
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    logic       par;
    bit         align;
    int         gap;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;
  vec_t vecs[$];

  initial begin
    vecs.push_back('{"f55",   8'h55, 1'b1, 1'b0, 1'b0, 10, 8'h55, 1'b0, 1'b0});
    vecs.push_back('{"fA3",   8'hA3, 1'b1, 1'b0, 1'b0,  0, 8'hA3, 1'b0, 1'b0});
    vecs.push_back('{"f0F",   8'h0F, 1'b1, 1'b0, 1'b0, 10, 8'h0F, 1'b0, 1'b0});
    vecs.push_back('{"f81fe", 8'h81, 1'b0, 1'b0, 1'b0, 20, 8'h81, 1'b1, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{"p07ok", 8'h07, 1'b1, 1'b1, 1'b0, 10, 8'h07, 1'b0, 1'b0});
    vecs.push_back('{"p07er", 8'h07, 1'b1, 1'b0, 1'b0, 10, 8'h07, 1'b0, 1'b1});
`endif
    vecs.push_back('{"f00al", 8'h00, 1'b1, 1'b0, 1'b1, 10, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"fFF",   8'hFF, 1'b1, 1'b0, 1'b0, 10, 8'hFF, 1'b0, 1'b0});

    bus.rx = 1'b1;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_rx_done", bus.rx_done, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_parity_err", bus.parity_err, 1'b0);
    rst = 1'b1;
    wait_ticks(4);

    foreach (vecs[i]) begin
      run_frame(vecs[i].name, vecs[i].data, vecs[i].stop, vecs[i].par,
                vecs[i].align, vecs[i].exp_d, vecs[i].exp_fe, vecs[i].exp_pe);
      wait_ticks(vecs[i].gap);
    end

    // Short low glitch: START rejects it at mid-bit and reports nothing.
    #1 bus.rx = 1'b0;
    wait_ticks(3);
    #1 bus.rx = 1'b1;
    wait_ticks(40);
    check("glitch_no_done", evq.size(), 0);
    check("glitch_dout_held", bus.dout, 8'hFF);
    run_frame("after_glitch", 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    wait_ticks(10);

    // Reset during data bit 4 abandons the frame.
    #1 bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      #1 bus.rx = (i % 2 == 1);
      wait_ticks(16);
    end
    #1 bus.rx = 1'b0;
    wait_ticks(8);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_dout", bus.dout, 8'h00);
    bus.rx = 1'b1;
    rst    = 1'b1;
    wait_ticks(32);
    check("midrst_no_done", evq.size(), 0);
    run_frame("after_rst", 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    wait_ticks(10);

    check("stray_pulses", stray, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard ceiling so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
